// File: rtl/axi_aw_issuer.sv
// axi_aw_issuer
// Write-address issuer for the debug AXI-over-UART bridge. Accepts decoded
// write commands, screens them for burst legality, drives the AW channel,
// keeps count of bursts awaiting a B response and reports completions and
// errors back to the command parser.

module axi_aw_issuer #(
  parameter int MAXOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [2:0]  cmd_size,
  input  logic [1:0]  cmd_burst,
  // AXI AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // AXI B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // status
  output logic [3:0]  outstanding,
  output logic        done_pulse,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic        idle
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ADDR = 1'b1
  } state_t;

  localparam logic [3:0] MAX_OUT = 4'(MAXOUT);

  state_t      state;
  logic [3:0]  exp_bid;

  logic        cmd_fire;
  logic        aw_fire;
  logic        b_fire;
  logic        cmd_legal;
  logic        reject;
  logic        bad_resp;
  logic [8:0]  beats;
  logic [13:0] burst_bytes;
  logic [13:0] incr_end;
  logic [16:0] err_sum;
  logic [15:0] err_next;

  // Handshake and flow-control terms; cmd_ready and bready come straight from
  // state and the outstanding counter so they never wait on the other side.
  always_comb begin
    cmd_ready = (state == IDLE) && (outstanding < MAX_OUT);
    bready    = (outstanding != 4'd0);
    idle      = (state == IDLE) && (outstanding == 4'd0);
    cmd_fire  = cmd_valid && cmd_ready;
    aw_fire   = awvalid && awready;
    b_fire    = bvalid && bready;
    bad_resp  = b_fire && ((bid != exp_bid) || (bresp != 2'd0));
  end

  // Burst legality screen: bus is 32 bits wide, INCR must stay inside one 4KB
  // page, WRAP needs 2/4/8/16 beats and FIXED is capped at 16 beats.
  always_comb begin
    beats       = {1'b0, cmd_len} + 9'd1;
    burst_bytes = {5'b0, beats} << cmd_size;
    incr_end    = {2'b00, cmd_addr[11:0]} + burst_bytes;
    cmd_legal   = 1'b1;
    if (cmd_size > 3'd2) begin
      cmd_legal = 1'b0;
    end
    case (cmd_burst)
      2'd0: if (cmd_len > 8'd15) cmd_legal = 1'b0;
      2'd1: if (incr_end > 14'd4096) cmd_legal = 1'b0;
      2'd2: if (!((cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                  (cmd_len == 8'd7) || (cmd_len == 8'd15))) cmd_legal = 1'b0;
      default: cmd_legal = 1'b0;
    endcase
    reject = cmd_fire && !cmd_legal;
  end

  // A rejected command and a bad response in the same cycle add two errors;
  // the counter sticks at all-ones rather than wrapping.
  always_comb begin
    err_sum  = {1'b0, err_count} + {16'b0, reject} + {16'b0, bad_resp};
    err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Issuer FSM with all registered outputs: latches legal commands onto AW,
  // tracks outstanding bursts and the expected in-order response id.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      awvalid     <= 1'b0;
      awid        <= 4'd0;
      awaddr      <= 32'd0;
      awlen       <= 8'd0;
      awsize      <= 3'd0;
      awburst     <= 2'd0;
      outstanding <= 4'd0;
      exp_bid     <= 4'd0;
      done_pulse  <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= 16'd0;
    end else begin
      done_pulse <= b_fire;
      err_pulse  <= reject || bad_resp;
      err_count  <= err_next;

      if (b_fire) begin
        exp_bid <= exp_bid + 4'd1;
      end

      case ({aw_fire, b_fire})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase

      case (state)
        IDLE: begin
          if (cmd_fire && cmd_legal) begin
            awaddr  <= cmd_addr;
            awlen   <= cmd_len;
            awsize  <= cmd_size;
            awburst <= cmd_burst;
            awvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (aw_fire) begin
            awid    <= awid + 4'd1;
            awvalid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          awvalid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_aw_issuer.sv
// tb_axi_aw_issuer
// Directed bench for axi_aw_issuer with MAXOUT = 8. Every step drives inputs
// just after a rising edge and compares outputs against hand-computed values.

module tb_axi_aw_issuer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  outstanding;
  logic        done_pulse;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        idle;

  int checkCount = 0;
  int passCount  = 0;

  axi_aw_issuer #(.MAXOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_size    (cmd_size),
    .cmd_burst   (cmd_burst),
    .awid        (awid),
    .awaddr      (awaddr),
    .awlen       (awlen),
    .awsize      (awsize),
    .awburst     (awburst),
    .awvalid     (awvalid),
    .awready     (awready),
    .bid         (bid),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .outstanding (outstanding),
    .done_pulse  (done_pulse),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .idle        (idle)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just past the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the command request fields
  task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
    cmd_valid = valid;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
  endtask

  // Drive the B channel
  task automatic applyResponse(input logic valid, input logic [3:0] id,
                               input logic [1:0] resp);
    bvalid = valid;
    bid    = id;
    bresp  = resp;
  endtask

  // One comparison: counts it, and reports a failure with $error
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount = checkCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // Hold reset for two cycles with all inputs quiet
  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    applyResponse(1'b0, 4'd0, 2'd0);
    awready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    applyResponse(1'b0, 4'd0, 2'd0);
    awready = 1'b1;

    // ---- reset values ----
    resetDut();
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_awid", awid, 0);
    checkOutput("rst_awaddr", awaddr, 0);
    checkOutput("rst_awlen", awlen, 0);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_bready", bready, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_done", done_pulse, 0);
    checkOutput("rst_err", err_pulse, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_idle", idle, 1);

    // ---- single INCR command ----
    applyStimulus(1'b1, 32'h1000, 8'd3, 3'd2, 2'd1);
    tick();
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    checkOutput("t1_awvalid", awvalid, 1);
    checkOutput("t1_awid", awid, 0);
    checkOutput("t1_awlen", awlen, 3);
    checkOutput("t1_awaddr", awaddr, 32'h1000);
    checkOutput("t1_awsize", awsize, 2);
    checkOutput("t1_awburst", awburst, 1);
    checkOutput("t1_cmd_ready_addr", cmd_ready, 0);
    tick();
    checkOutput("t1_awvalid_drop", awvalid, 0);
    checkOutput("t1_outstanding1", outstanding, 1);
    checkOutput("t1_awid_inc", awid, 1);
    checkOutput("t1_bready", bready, 1);
    checkOutput("t1_idle_busy", idle, 0);
    tick();
    tick();
    applyResponse(1'b1, 4'd0, 2'd0);
    tick();
    applyResponse(1'b0, 4'd0, 2'd0);
    checkOutput("t1_done", done_pulse, 1);
    checkOutput("t1_outstanding0", outstanding, 0);
    checkOutput("t1_err", err_pulse, 0);
    tick();
    checkOutput("t1_done_low", done_pulse, 0);
    checkOutput("t1_err_count", err_count, 0);
    checkOutput("t1_idle", idle, 1);

    // ---- AW backpressure ----
    resetDut();
    awready = 1'b0;
    applyStimulus(1'b1, 32'h2000, 8'd0, 3'd0, 2'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_awvalid_hold", awvalid, 1);
      checkOutput("t2_awaddr_hold", awaddr, 32'h2000);
      checkOutput("t2_awid_hold", awid, 0);
      checkOutput("t2_cmd_ready", cmd_ready, 0);
      tick();
    end
    awready = 1'b1;
    checkOutput("t2_awvalid_final", awvalid, 1);
    tick();
    checkOutput("t2_awvalid_after", awvalid, 0);
    checkOutput("t2_awid_after", awid, 1);
    checkOutput("t2_outstanding", outstanding, 1);

    // ---- outstanding limit ----
    resetDut();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h100 * i, 8'd0, 3'd2, 2'd1);
      tick();
      checkOutput("t3_awvalid", awvalid, 1);
      checkOutput("t3_awid", awid, i);
      tick();
      checkOutput("t3_outstanding", outstanding, i + 1);
    end
    applyStimulus(1'b1, 32'h900, 8'd0, 3'd2, 2'd1);
    checkOutput("t3_cmd_ready_full", cmd_ready, 0);
    tick();
    checkOutput("t3_no_ninth", awvalid, 0);
    checkOutput("t3_still_full", outstanding, 8);
    checkOutput("t3_cmd_ready_held", cmd_ready, 0);
    applyResponse(1'b1, 4'd0, 2'd0);
    tick();
    applyResponse(1'b0, 4'd0, 2'd0);
    checkOutput("t3_after_b", outstanding, 7);
    checkOutput("t3_cmd_ready_back", cmd_ready, 1);
    checkOutput("t3_done", done_pulse, 1);
    tick();
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    checkOutput("t3_ninth_awvalid", awvalid, 1);
    checkOutput("t3_ninth_awid", awid, 8);
    checkOutput("t3_ninth_awaddr", awaddr, 32'h900);
    tick();
    checkOutput("t3_full_again", outstanding, 8);
    checkOutput("t3_cmd_ready_full2", cmd_ready, 0);

    // ---- illegal commands ----
    resetDut();
    // INCR of 16 bytes from 0xFF4 runs past the page end
    applyStimulus(1'b1, 32'hFF4, 8'd3, 3'd2, 2'd1);
    tick();
    checkOutput("t4_cross_err", err_pulse, 1);
    checkOutput("t4_cross_count", err_count, 1);
    checkOutput("t4_cross_noaw", awvalid, 0);
    checkOutput("t4_cross_ready", cmd_ready, 1);
    applyStimulus(1'b1, 32'h0, 8'd2, 3'd2, 2'd2);
    tick();
    checkOutput("t4_wrap_err", err_pulse, 1);
    checkOutput("t4_wrap_count", err_count, 2);
    checkOutput("t4_wrap_noaw", awvalid, 0);
    applyStimulus(1'b1, 32'h0, 8'd0, 3'd3, 2'd1);
    tick();
    checkOutput("t4_size_count", err_count, 3);
    checkOutput("t4_size_noaw", awvalid, 0);
    applyStimulus(1'b1, 32'h0, 8'd16, 3'd0, 2'd0);
    tick();
    checkOutput("t4_fixed_count", err_count, 4);
    applyStimulus(1'b1, 32'h0, 8'd0, 3'd0, 2'd3);
    tick();
    checkOutput("t4_burst3_count", err_count, 5);
    checkOutput("t4_burst3_noaw", awvalid, 0);
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    tick();
    checkOutput("t4_err_low", err_pulse, 0);
    // 16 bytes from 0xFF0 end exactly on the page boundary, so legal
    applyStimulus(1'b1, 32'hFF0, 8'd3, 3'd2, 2'd1);
    tick();
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    checkOutput("t4_edge_awvalid", awvalid, 1);
    checkOutput("t4_edge_err", err_pulse, 0);
    checkOutput("t4_edge_count", err_count, 5);
    tick();
    // WRAP of 8 beats is legal
    applyStimulus(1'b1, 32'h40, 8'd7, 3'd2, 2'd2);
    tick();
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    checkOutput("t4_wrap8_awvalid", awvalid, 1);
    checkOutput("t4_wrap8_awid", awid, 1);
    checkOutput("t4_wrap8_count", err_count, 5);

    // ---- bad responses ----
    resetDut();
    applyStimulus(1'b1, 32'h4000, 8'd1, 3'd1, 2'd1);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    tick();
    checkOutput("t5_outstanding2", outstanding, 2);
    checkOutput("t5_awid2", awid, 2);
    applyResponse(1'b1, 4'd0, 2'd2);
    tick();
    checkOutput("t5_b1_done", done_pulse, 1);
    checkOutput("t5_b1_err", err_pulse, 1);
    checkOutput("t5_b1_count", err_count, 1);
    checkOutput("t5_b1_outstanding", outstanding, 1);
    applyResponse(1'b1, 4'd5, 2'd0);
    tick();
    applyResponse(1'b0, 4'd0, 2'd0);
    checkOutput("t5_b2_done", done_pulse, 1);
    checkOutput("t5_b2_err", err_pulse, 1);
    checkOutput("t5_b2_count", err_count, 2);
    checkOutput("t5_b2_outstanding", outstanding, 0);
    tick();
    checkOutput("t5_done_low", done_pulse, 0);
    checkOutput("t5_err_low", err_pulse, 0);

    // ---- simultaneous AW and B handshakes ----
    resetDut();
    applyStimulus(1'b1, 32'h5000, 8'd0, 3'd2, 2'd1);
    tick();
    tick();
    tick();
    tick();
    checkOutput("t6_outstanding2", outstanding, 2);
    tick();
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    checkOutput("t6_third_awvalid", awvalid, 1);
    applyResponse(1'b1, 4'd0, 2'd0);
    tick();
    checkOutput("t6_both_outstanding", outstanding, 2);
    checkOutput("t6_both_awid", awid, 3);
    checkOutput("t6_both_done", done_pulse, 1);
    // rejected command and a doubly-bad response in one cycle add two errors
    applyStimulus(1'b1, 32'h0, 8'd0, 3'd0, 2'd3);
    applyResponse(1'b1, 4'd7, 2'd3);
    tick();
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    applyResponse(1'b0, 4'd0, 2'd0);
    checkOutput("t6_dual_err", err_pulse, 1);
    checkOutput("t6_dual_count", err_count, 2);
    checkOutput("t6_dual_outstanding", outstanding, 1);
    checkOutput("t6_dual_noaw", awvalid, 0);

    // ---- reset while in ADDR ----
    awready = 1'b0;
    applyStimulus(1'b1, 32'h3000, 8'd0, 3'd0, 2'd1);
    tick();
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    checkOutput("t7_awvalid_pre", awvalid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    awready = 1'b1;
    checkOutput("t7_awvalid", awvalid, 0);
    checkOutput("t7_awaddr", awaddr, 0);
    checkOutput("t7_awid", awid, 0);
    checkOutput("t7_outstanding", outstanding, 0);
    checkOutput("t7_err_count", err_count, 0);
    checkOutput("t7_cmd_ready", cmd_ready, 1);
    checkOutput("t7_bready", bready, 0);
    checkOutput("t7_idle", idle, 1);

    // ---- stray response with nothing outstanding is ignored ----
    applyResponse(1'b1, 4'd3, 2'd2);
    tick();
    applyResponse(1'b0, 4'd0, 2'd0);
    checkOutput("t8_done", done_pulse, 0);
    checkOutput("t8_err", err_pulse, 0);
    checkOutput("t8_count", err_count, 0);
    checkOutput("t8_outstanding", outstanding, 0);
    // exp_bid untouched: a response with id 0 after a fresh burst is good
    applyStimulus(1'b1, 32'h6000, 8'd0, 3'd0, 2'd1);
    tick();
    applyStimulus(1'b0, 32'd0, 8'd0, 3'd0, 2'd0);
    tick();
    applyResponse(1'b1, 4'd0, 2'd0);
    tick();
    applyResponse(1'b0, 4'd0, 2'd0);
    checkOutput("t8_good_done", done_pulse, 1);
    checkOutput("t8_good_err", err_pulse, 0);
    checkOutput("t8_good_count", err_count, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
